if_id_stage: RTL

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// Instruction-fetch stage with IF/ID pipeline latch: PC sequencing, branch/jump redirects,
// data-dependence stalls and a sticky halt that only reset can clear.
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nop_lock_id,
   input  logic [1:0]  Jump_id,
   input  logic [31:0] jump_target_id,
   input  logic [31:0] jr_target_id,
   input  logic        branch_taken_ex,
   input  logic [31:0] branch_target_ex,
   input  logic        halt,
   input  logic [31:0] imem_data,
   output logic [31:0] imem_addr,
   output logic [31:0] instr_if_id,
   output logic [31:0] pc_plus4_if_id,
   output logic        valid_if_id,
   output logic        bubble_id_ex,
   output logic        halted,
   output logic [31:0] stall_count
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   localparam logic [1:0] JUMP_NONE = 2'b00;
   localparam logic [1:0] JUMP_JR   = 2'b01;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] stall_q, stall_d;
   logic [31:0] pc_plus4;
   logic        bubble;

   assign pc_plus4 = pc_q + 32'd4;

   // NOTE: every variable is given its hold value first so no path through the
   // priority chain leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      stall_d = stall_q;
      bubble  = 1'b0;
      if (state_q == RUN) begin
         if (halt) begin
            state_d = HALTED;
         end else if (branch_taken_ex) begin
            pc_d    = {branch_target_ex[31:2], 2'b00};
            instr_d = 32'h0;
            valid_d = 1'b0;
            bubble  = 1'b1;
         end else if (nop_lock_id) begin
            if (stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
            bubble = 1'b1;
         end else if ((Jump_id != JUMP_NONE) && valid_q) begin
            // Link value in pc_plus4_if_id is kept so the jal in ID can still write it back.
            pc_d    = (Jump_id == JUMP_JR) ? {jr_target_id[31:2], 2'b00}
                                           : {jump_target_id[31:2], 2'b00};
            instr_d = 32'h0;
            valid_d = 1'b0;
         end else begin
            pc_d    = pc_plus4;
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update
   // together from values sampled before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
         stall_q <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         stall_q <= stall_d;
      end
   end

   assign imem_addr      = pc_q;
   assign instr_if_id    = instr_q;
   assign pc_plus4_if_id = pc4_q;
   assign valid_if_id    = valid_q;
   assign halted         = (state_q == HALTED);
   assign stall_count    = stall_q;
   assign bubble_id_ex   = bubble && rst_n;

endmodule
